alu_seq: RTL

- Parametrised, registered successor to the 16-bit combinational ALU.
- Width is configurable; adds status flags, an iterative multiply, and valid/ready handshakes on input and output.
- Sits between the register-file read stage and writeback.
- Single-cycle ops complete in 1 cycle; MUL is multi-cycle. The block stalls upstream and honours downstream backpressure.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 69 ++++++
 rtl/alu_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encoding, control states, status flags.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring MUL_BPC multiplier bits per cycle.
// 'done' is high during the final step; 'product' then already includes that step.
module alu_mul_iter #(
  parameter int WIDTH   = 16,
  parameter int MUL_BPC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int STEPS = WIDTH / MUL_BPC;
  localparam int CW    = $clog2(STEPS + 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] pp_terms [MUL_BPC];
  logic [2*WIDTH-1:0] pp_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic               busy;

  // One partial product per multiplier bit retired this cycle
  genvar gi;
  generate
    for (gi = 0; gi < MUL_BPC; gi++) begin : g_pp
      assign pp_terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // Sum this cycle's partial products into the running accumulator
  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_BPC; i++) begin
      pp_sum = pp_sum + pp_terms[i];
    end
    acc_next = acc_reg + pp_sum;
  end

  assign busy    = (count_reg != '0);
  assign done    = (count_reg == CW'(1));
  assign product = acc_next;

  // Load operands on start, then step once per cycle until the counter empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      count_reg  <= CW'(STEPS);
    end else if (busy) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << MUL_BPC;
      mplier_reg <= mplier_reg >> MUL_BPC;
      count_reg  <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative MUL.
// Single-cycle ops have latency 1; MUL takes WIDTH/MUL_BPC cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MUL_BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e         state_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   result_reg;
  alu_flags_t         flags_reg;

  alu_op_e            op_e;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [SW-1:0]      shamt;
  logic               is_sub;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = !rst && (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_e == OP_MUL);

  alu_mul_iter #(
    .WIDTH   (WIDTH),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Adder shared by ADD/SUB (SUB as a + ~b + 1); shifts widened by one bit to catch shift-out
  assign shamt  = b[SW-1:0];
  assign is_sub = (op_e == OP_SUB);
  assign add_b  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
  assign shl_w  = {1'b0, a} << shamt;
  assign shr_w  = {a, 1'b0} >> shamt;

  // Single-cycle result and carry/overflow selection
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op_e)
      OP_ADD, OP_SUB: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      default: ;
    endcase
  end

  // Control state, output register and handshake bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (op_e == OP_MUL) begin
              state_reg     <= MUL;
              out_valid_reg <= 1'b0;
            end else begin
              result_reg    <= sc_res;
              flags_reg.z   <= (sc_res == '0);
              flags_reg.n   <= sc_res[WIDTH-1];
              flags_reg.c   <= sc_c;
              flags_reg.v   <= sc_v;
              out_valid_reg <= 1'b1;
            end
          end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            result_reg    <= mul_product[WIDTH-1:0];
            flags_reg.z   <= (mul_product[WIDTH-1:0] == '0);
            flags_reg.n   <= mul_product[WIDTH-1];
            flags_reg.c   <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            flags_reg.v   <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            out_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flag_z    = flags_reg.z;
  assign flag_n    = flags_reg.n;
  assign flag_c    = flags_reg.c;
  assign flag_v    = flags_reg.v;

endmodule
